// File: rtl/seg_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder_if
// Bundle between a multiplexed 7-segment display bus and the scan decoder
// that monitors it.
//   an[DIGITS-1:0]       anode enables, active-low, one low bit selects a digit
//   seg[7:0]             segments, active-low, bit0=a .. bit6=g, bit7=dp
//   clear                synchronous clear of the decoded state
//   digits[4*DIGITS-1:0] decoded nibble per digit, digit i at [4i+3:4i]
//   valid/blank/err      per-digit status flags
//   update, upd_idx      one-cycle capture pulse and the captured digit index
// master: the display side / observer; slave: the decoder.
// ---------------------------------------------------------------------------
interface seg_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;
    logic                clear;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   valid;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   err;
    logic                update;
    logic [2:0]          upd_idx;

    modport master (
        output an, seg, clear,
        input  digits, valid, blank, err, update, upd_idx
    );

    modport slave (
        input  an, seg, clear,
        output digits, valid, blank, err, update, upd_idx
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
// Watches a multiplexed 7-segment display bus and rebuilds the hex nibble
// shown on each digit. A pattern {an, seg[6:0]} must stay identical for
// STABLE_CYCLES consecutive edges before it is accepted; each accepted
// pattern is decoded into a per-digit register, blanks and illegal codes are
// flagged.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    seg_scan_decoder_if.slave (an, seg, clear in; digits, valid,
//          blank, err, update, upd_idx out)
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_decoder_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = DIGITS + 7;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);

    // Returns {legal, nibble} for an active-low a..g segment code.
    function automatic logic [4:0] decode_seg(input logic [6:0] code);
        case (code)
            7'h40:   decode_seg = {1'b1, 4'h0};
            7'h79:   decode_seg = {1'b1, 4'h1};
            7'h24:   decode_seg = {1'b1, 4'h2};
            7'h30:   decode_seg = {1'b1, 4'h3};
            7'h19:   decode_seg = {1'b1, 4'h4};
            7'h12:   decode_seg = {1'b1, 4'h5};
            7'h02:   decode_seg = {1'b1, 4'h6};
            7'h78:   decode_seg = {1'b1, 4'h7};
            7'h00:   decode_seg = {1'b1, 4'h8};
            7'h18:   decode_seg = {1'b1, 4'h9};
            7'h08:   decode_seg = {1'b1, 4'hA};
            7'h03:   decode_seg = {1'b1, 4'hB};
            7'h46:   decode_seg = {1'b1, 4'hC};
            7'h21:   decode_seg = {1'b1, 4'hD};
            7'h06:   decode_seg = {1'b1, 4'hE};
            7'h0E:   decode_seg = {1'b1, 4'hF};
            default: decode_seg = 5'h00;
        endcase
    endfunction

    logic [SW-1:0]       s_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                update_q, update_d;
    logic [2:0]          upd_idx_q, upd_idx_d;

    logic [DIGITS-1:0]   an_n;
    logic                one_hot;
    logic [SW-1:0]       cur;
    logic                same;
    logic                capture;
    logic [4:0]          dec;
    logic                dp_unused;

    // The decimal point never takes part in stability or decoding.
    assign dp_unused = bus.seg[7];

    always_comb begin
        an_n    = ~bus.an;
        one_hot = (an_n != '0) && ((an_n & (an_n - DIGITS'(1))) == '0);
        cur     = {bus.an, bus.seg[6:0]};
        same    = (cur == s_q);
        dec     = decode_seg(bus.seg[6:0]);

        // Stability counter: cleared while no single digit is selected,
        // restarted on any change, saturated once the window is complete.
        if (!one_hot) begin
            cnt_d = '0;
        end else if (!same) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Fires only on the edge that moves cnt to CNT_MAX, so a held
        // pattern is captured exactly once.
        capture = one_hot && same && (cnt_q == CNT_ARM);

        digits_d  = digits_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        err_d     = err_q;
        update_d  = 1'b0;
        upd_idx_d = upd_idx_q;

        if (bus.clear) begin
            digits_d = '0;
            valid_d  = '0;
            blank_d  = '0;
            err_d    = '0;
        end else if (capture) begin
            update_d = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (an_n[i]) begin
                    upd_idx_d = 3'(i);
                    if (dec[4]) begin
                        digits_d[4*i +: 4] = dec[3:0];
                        valid_d[i]         = 1'b1;
                        blank_d[i]         = 1'b0;
                    end else if (bus.seg[6:0] == 7'h7F) begin
                        blank_d[i] = 1'b1;
                        valid_d[i] = 1'b0;
                    end else begin
                        err_d[i]   = 1'b1;
                        valid_d[i] = 1'b0;
                        blank_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q       <= '1;
            cnt_q     <= '0;
            digits_q  <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            err_q     <= '0;
            update_q  <= 1'b0;
            upd_idx_q <= 3'd0;
        end else begin
            s_q       <= cur;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            update_q  <= update_d;
            upd_idx_q <= upd_idx_d;
        end
    end

    assign bus.digits  = digits_q;
    assign bus.valid   = valid_q;
    assign bus.blank   = blank_q;
    assign bus.err     = err_q;
    assign bus.update  = update_q;
    assign bus.upd_idx = upd_idx_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reverse path of the hex-to-7-segment decoder: watches a multiplexed 7-segment display bus (active-low anodes plus active-low segments) and rebuilds the hex nibble shown on each digit.
- A pattern is accepted only after it has been stable for a set number of cycles; each accepted pattern is decoded into a per-digit register, and illegal patterns are flagged.
- Used as an on-chip display monitor and as a self-check for the display path.
- Inputs are synchronous to clk and come from the same clock domain as the display driver.

Parameters:
- DIGITS, 4, number of multiplexed digits (anode lines); legal range 1..8.
- STABLE_CYCLES, 4, consecutive identical cycles required before a capture; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- an  input  DIGITS  anode enables, active-low; exactly one low bit selects a digit.
- seg  input  8  segments, active-low; bit0=a … bit6=g; bit7 (dp) is ignored.
- clear  input  1  synchronous; clears digits, valid and err.
- digits  output  4*DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- valid  output  DIGITS  digit i currently holds a legally decoded nibble.
- blank  output  DIGITS  last accepted pattern on digit i was all segments off.
- err  output  DIGITS  sticky flag: an illegal pattern was accepted on digit i.
- update  output  1  one-cycle pulse on every accepted pattern.
- upd_idx  output  3  index of the digit accepted; meaningful only while update=1.

Behaviour:
- Reset (asynchronous, active-high): digits=0, valid=0, blank=0, err=0, update=0, upd_idx=0, sample register=all ones, counter=0.
- Sample register s holds {an, seg[6:0]} from the previous edge. Counter cnt has width ceil(log2(STABLE_CYCLES+1)) and saturates at STABLE_CYCLES.
- At each edge, when an is one-hot-low:
  - if the current input equals s, cnt<=min(cnt+1, STABLE_CYCLES);
  - otherwise cnt<=1.
- At each edge, when an is not one-hot-low (all ones, or two or more zeros): cnt<=0 and no capture. s is always loaded with the current input.
- Capture condition: cnt==STABLE_CYCLES-1, input equals s, and an is one-hot-low.
  - Results are registered on that edge. cnt becomes STABLE_CYCLES, so exactly one capture happens per stable window.
  - A pattern held for a long time does not re-capture.
- Latency: a pattern first present at edge t0 and held produces update=1 and updated outputs after edge t0+STABLE_CYCLES-1.
- Decode table, seg[6:0] in hex -> nibble: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
- On capture for digit i = index of the low an bit:
  - Legal code: digits[i]=nibble, valid[i]=1, blank[i]=0. err[i] is unchanged.
  - 7F (all off): blank[i]=1, valid[i]=0, digits[i] is unchanged, err[i] is unchanged.
  - Any other code: err[i]=1, valid[i]=0, blank[i]=0, digits[i] is unchanged.
  - In all three cases, update=1 and upd_idx=i for one cycle.
- clear=1: digits, valid, blank and err go to 0, and update is forced to 0 that cycle. s and cnt keep running. A capture that coincides with clear is discarded.
- A change in seg or an before cnt reaches the threshold restarts the count (glitch filter). A change on dp alone does not restart it.
- Reset asserted mid-window drops the pending capture. After release, a full STABLE_CYCLES window is needed again.

Test Plan:
- After reset, hold an=1110, seg=8'hA4 for 6 cycles -> one update pulse after edge t0+3, upd_idx=0, digits[3:0]=2, valid=0001, err=0.
- Scan all 16 codes on digit 2 (an=1011), each held 4 cycles -> 16 update pulses, and digits[11:8] follows 0..F in order.
- Hold an=1101, seg=8'h7F -> blank=0010, valid[1]=0. Then seg=8'hFF with dp toggled, still 7F on [6:0] -> no restart of the count and no second update.
- Apply illegal pattern seg=8'h55 on digit 3 -> err=1000, and digits[15:12] keeps its prior value. A later legal 8'h40 gives valid[3]=1, err still 1000. Then pulse clear -> all outputs 0.
- Glitch test: an=1110, seg=8'h79 for 2 cycles, then 8'h24 for 4 cycles -> exactly one update, with digits[3:0]=2.
- Glitch test: an=1100 or an=1111 held 10 cycles -> no update.
- Assert reset at cnt=2 of a window -> all outputs 0, and a capture needs 4 more stable cycles after release.
